// File: rtl/operand_fetch_if.sv
// operand_fetch_if: decoder, writeback, register file and ALU signals of the operand fetch controller.
interface operand_fetch_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
);
    logic              issue_valid;
    logic              issue_ready;
    logic [ADDR_W-1:0] issue_src1;
    logic [ADDR_W-1:0] issue_src2;
    logic [ADDR_W-1:0] issue_dest;
    logic              wb_valid;
    logic              wb_ready;
    logic [ADDR_W-1:0] wb_dest;
    logic [DATA_W-1:0] wb_data;
    logic              rf_write_en;
    logic [ADDR_W-1:0] rf_write_dest;
    logic [DATA_W-1:0] rf_write_data;
    logic              rf_read_en;
    logic [ADDR_W-1:0] rf_read_addr_1;
    logic [ADDR_W-1:0] rf_read_addr_2;
    logic [DATA_W-1:0] rf_read_data_1;
    logic [DATA_W-1:0] rf_read_data_2;
    logic              op_valid;
    logic              op_ready;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [ADDR_W-1:0] op_dest;
    modport master (
        input  issue_valid, issue_src1, issue_src2, issue_dest,
        input  wb_valid, wb_dest, wb_data,
        input  rf_read_data_1, rf_read_data_2, op_ready,
        output issue_ready, wb_ready,
        output rf_write_en, rf_write_dest, rf_write_data,
        output rf_read_en, rf_read_addr_1, rf_read_addr_2,
        output op_valid, op_a, op_b, op_dest
    );
    modport slave (
        output issue_valid, issue_src1, issue_src2, issue_dest,
        output wb_valid, wb_dest, wb_data,
        output rf_read_data_1, rf_read_data_2, op_ready,
        input  issue_ready, wb_ready,
        input  rf_write_en, rf_write_dest, rf_write_data,
        input  rf_read_en, rf_read_addr_1, rf_read_addr_2,
        input  op_valid, op_a, op_b, op_dest
    );
endinterface

// File: rtl/operand_fetch_ctrl.sv
// operand_fetch_ctrl: sequences register file reads around priority writebacks and hands operands to the ALU.
module operand_fetch_ctrl #(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 5,
    parameter int STARVE_LIMIT = 4
) (
    input logic clk,
    input logic rst,
    operand_fetch_if.master bus
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    typedef enum logic [1:0] {IDLE, RD, WAIT, HOLD} state_t;
    state_t            state, state_nxt;
    logic [CW-1:0]     starve_cnt;
    logic [ADDR_W-1:0] src1_q, src2_q, dest_q;
    logic              issue_fire;
    always_comb begin
        // A starved read wins one cycle by refusing the writeback
        bus.wb_ready       = !rst && !(state == RD && starve_cnt == CW'(STARVE_LIMIT));
        bus.rf_write_en    = bus.wb_valid && bus.wb_ready;
        bus.rf_write_dest  = rst ? '0 : bus.wb_dest;
        bus.rf_write_data  = rst ? '0 : bus.wb_data;
        bus.rf_read_en     = !rst && state == RD && !bus.rf_write_en;
        bus.rf_read_addr_1 = rst ? '0 : src1_q;
        bus.rf_read_addr_2 = rst ? '0 : src2_q;
        bus.issue_ready    = !rst && (state == IDLE || (state == HOLD && bus.op_ready));
        bus.op_valid       = !rst && state == HOLD;
        issue_fire         = bus.issue_valid && bus.issue_ready;
        state_nxt          = state;
        case (state)
            IDLE:    state_nxt = issue_fire ? RD : IDLE;
            RD:      state_nxt = bus.rf_read_en ? WAIT : RD;
            WAIT:    state_nxt = HOLD;
            default: state_nxt = !bus.op_ready ? HOLD : issue_fire ? RD : IDLE;
        endcase
    end
    always_ff @(posedge clk)
        state <= rst ? IDLE : state_nxt;
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt  <= '0;
            src1_q      <= '0;
            src2_q      <= '0;
            dest_q      <= '0;
            bus.op_a    <= '0;
            bus.op_b    <= '0;
            bus.op_dest <= '0;
        end else begin
            if (issue_fire) begin
                src1_q <= bus.issue_src1;
                src2_q <= bus.issue_src2;
                dest_q <= bus.issue_dest;
            end
            if (state == RD)
                starve_cnt <= bus.rf_read_en ? '0 : starve_cnt + 1'b1;
            if (state == WAIT) begin
                bus.op_a    <= bus.rf_read_data_1;
                bus.op_b    <= bus.rf_read_data_2;
                bus.op_dest <= dest_q;
            end
        end
    end
endmodule

// File: tb/tb_operand_fetch_ctrl.sv
// tb_operand_fetch_ctrl: directed vectors and corner sequences against a registered-read register file model.
module tb_operand_fetch_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad = 0;
    logic [15:0] rf [32] = '{default: 16'h0};
    operand_fetch_if #(.DATA_W(16), .ADDR_W(5)) bus ();
    operand_fetch_ctrl #(.DATA_W(16), .ADDR_W(5), .STARVE_LIMIT(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;
    // Register file: writes and reads on the rising edge, read data one cycle later
    always @(posedge clk) begin
        if (bus.rf_write_en) rf[bus.rf_write_dest] <= bus.rf_write_data;
        if (bus.rf_read_en) begin
            bus.rf_read_data_1 <= rf[bus.rf_read_addr_1];
            bus.rf_read_data_2 <= rf[bus.rf_read_addr_2];
        end
    end
    typedef struct {
        logic r, iv; logic [4:0] s1, s2, d; logic wv; logic [4:0] wd; logic [15:0] wdat; logic ordy;
        logic ir, wr, we, re, ov; logic [15:0] a, b; logic [4:0] od;
    } vec_t;
    vec_t vt [9];
    task automatic tick();
        @(posedge clk);
        #2;
    endtask
    task automatic drv(input logic r, input logic iv, input logic [4:0] s1, input logic [4:0] s2,
                       input logic [4:0] d, input logic wv, input logic [4:0] wd,
                       input logic [15:0] wdat, input logic ordy);
        rst = r;
        bus.issue_valid = iv;
        bus.issue_src1 = s1;
        bus.issue_src2 = s2;
        bus.issue_dest = d;
        bus.wb_valid = wv;
        bus.wb_dest = wd;
        bus.wb_data = wdat;
        bus.op_ready = ordy;
        #1;
    endtask
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask
    initial begin
        vt[0] = '{1,0,0,0,0,0,0,16'h0,0,    0,0,0,0,0,16'h0,16'h0,0};
        vt[1] = '{0,0,0,0,0,1,3,16'h1234,0, 1,1,1,0,0,16'h0,16'h0,0};
        vt[2] = '{0,0,0,0,0,1,7,16'hBEEF,0, 1,1,1,0,0,16'h0,16'h0,0};
        vt[3] = '{0,1,3,7,9,0,0,16'h0,0,    1,1,0,0,0,16'h0,16'h0,0};
        vt[4] = '{0,0,0,0,0,0,0,16'h0,0,    0,1,0,1,0,16'h0,16'h0,0};
        vt[5] = '{0,0,0,0,0,0,0,16'h0,0,    0,1,0,0,0,16'h0,16'h0,0};
        vt[6] = '{0,0,0,0,0,0,0,16'h0,0,    0,1,0,0,1,16'h1234,16'hBEEF,9};
        vt[7] = '{0,0,0,0,0,0,0,16'h0,1,    1,1,0,0,1,16'h1234,16'hBEEF,9};
        vt[8] = '{0,0,0,0,0,0,0,16'h0,0,    1,1,0,0,0,16'h1234,16'hBEEF,9};
        drv(1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < 9; i++) begin
            drv(vt[i].r, vt[i].iv, vt[i].s1, vt[i].s2, vt[i].d, vt[i].wv, vt[i].wd, vt[i].wdat, vt[i].ordy);
            chk($sformatf("v%0d_issue_ready", i), 32'(bus.issue_ready), 32'(vt[i].ir));
            chk($sformatf("v%0d_wb_ready", i), 32'(bus.wb_ready), 32'(vt[i].wr));
            chk($sformatf("v%0d_rf_write_en", i), 32'(bus.rf_write_en), 32'(vt[i].we));
            chk($sformatf("v%0d_rf_read_en", i), 32'(bus.rf_read_en), 32'(vt[i].re));
            chk($sformatf("v%0d_op_valid", i), 32'(bus.op_valid), 32'(vt[i].ov));
            chk($sformatf("v%0d_op_a", i), 32'(bus.op_a), 32'(vt[i].a));
            chk($sformatf("v%0d_op_b", i), 32'(bus.op_b), 32'(vt[i].b));
            chk($sformatf("v%0d_op_dest", i), 32'(bus.op_dest), 32'(vt[i].od));
            tick();
        end
        // Writeback starvation: four blocked RD cycles, then one refused writeback
        drv(0, 1, 1, 2, 4, 0, 0, 0, 0);
        chk("starve_accept", 32'(bus.issue_ready), 1);
        tick();
        for (int k = 0; k < 4; k++) begin
            drv(0, 0, 0, 0, 0, 1, 2, 16'h00AA, 0);
            chk($sformatf("starve%0d_read_en", k), 32'(bus.rf_read_en), 0);
            chk($sformatf("starve%0d_wb_ready", k), 32'(bus.wb_ready), 1);
            chk($sformatf("starve%0d_write_en", k), 32'(bus.rf_write_en), 1);
            tick();
        end
        drv(0, 0, 0, 0, 0, 1, 2, 16'h00AA, 0);
        chk("starve_refuse_wb_ready", 32'(bus.wb_ready), 0);
        chk("starve_refuse_read_en", 32'(bus.rf_read_en), 1);
        chk("starve_refuse_write_en", 32'(bus.rf_write_en), 0);
        tick();
        drv(0, 0, 0, 0, 0, 1, 2, 16'h00AA, 0);
        chk("starve_wait_wb_ready", 32'(bus.wb_ready), 1);
        tick();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("starve_op_valid", 32'(bus.op_valid), 1);
        chk("starve_op_a", 32'(bus.op_a), 32'h0);
        chk("starve_op_b", 32'(bus.op_b), 32'h00AA);
        chk("starve_op_dest", 32'(bus.op_dest), 4);
        tick();
        // Backpressure in HOLD, then back-to-back issue on release
        drv(0, 1, 3, 7, 11, 0, 0, 0, 0);
        tick();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        for (int k = 0; k < 5; k++) begin
            drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
            chk($sformatf("hold%0d_op_valid", k), 32'(bus.op_valid), 1);
            chk($sformatf("hold%0d_op_a", k), 32'(bus.op_a), 32'h1234);
            chk($sformatf("hold%0d_op_b", k), 32'(bus.op_b), 32'hBEEF);
            chk($sformatf("hold%0d_op_dest", k), 32'(bus.op_dest), 11);
            chk($sformatf("hold%0d_issue_ready", k), 32'(bus.issue_ready), 0);
            tick();
        end
        drv(0, 1, 7, 3, 12, 0, 0, 0, 1);
        chk("b2b_issue_ready", 32'(bus.issue_ready), 1);
        tick();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("b2b_c1_op_valid", 32'(bus.op_valid), 0);
        chk("b2b_c1_read_en", 32'(bus.rf_read_en), 1);
        tick();
        chk("b2b_c2_op_valid", 32'(bus.op_valid), 0);
        tick();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("b2b_c3_op_valid", 32'(bus.op_valid), 1);
        chk("b2b_op_a", 32'(bus.op_a), 32'hBEEF);
        chk("b2b_op_b", 32'(bus.op_b), 32'h1234);
        chk("b2b_op_dest", 32'(bus.op_dest), 12);
        tick();
        // Writeback during WAIT is not forwarded into the captured operand
        drv(0, 1, 5, 5, 1, 0, 0, 0, 0);
        tick();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drv(0, 0, 0, 0, 0, 1, 5, 16'h0001, 0);
        chk("waitwb_write_en", 32'(bus.rf_write_en), 1);
        tick();
        drv(0, 1, 5, 5, 1, 0, 0, 0, 1);
        chk("waitwb_old_op_a", 32'(bus.op_a), 32'h0);
        tick();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("waitwb_new_op_valid", 32'(bus.op_valid), 1);
        chk("waitwb_new_op_a", 32'(bus.op_a), 32'h0001);
        tick();
        // Reset asserted while in WAIT
        drv(0, 1, 3, 7, 2, 0, 0, 0, 0);
        tick();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drv(1, 0, 0, 0, 0, 1, 4, 16'h5555, 0);
        chk("rst_wb_ready", 32'(bus.wb_ready), 0);
        chk("rst_write_en", 32'(bus.rf_write_en), 0);
        chk("rst_read_en", 32'(bus.rf_read_en), 0);
        tick();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("post_rst_op_valid", 32'(bus.op_valid), 0);
        chk("post_rst_op_a", 32'(bus.op_a), 32'h0);
        chk("post_rst_op_dest", 32'(bus.op_dest), 0);
        chk("post_rst_issue_ready", 32'(bus.issue_ready), 1);
        chk("post_rst_read_en", 32'(bus.rf_read_en), 0);
        tick();
        // Address range extremes r0 and r31
        drv(0, 0, 0, 0, 0, 1, 0, 16'hFFFF, 0);
        tick();
        drv(0, 0, 0, 0, 0, 1, 31, 16'hFFFF, 0);
        tick();
        drv(0, 1, 0, 31, 31, 0, 0, 0, 0);
        tick();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("range_addr_2", 32'(bus.rf_read_addr_2), 31);
        tick();
        tick();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("range_op_a", 32'(bus.op_a), 32'hFFFF);
        chk("range_op_b", 32'(bus.op_b), 32'hFFFF);
        chk("range_op_dest", 32'(bus.op_dest), 31);
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
